// File: rtl/mux_4_1_n_bit_rr.sv
// Four-channel N-bit stream merger with round-robin arbitration and a registered output stage.
// Each output word carries its source channel index on {s1,s0}, which a downstream demux can use to re-split the stream.
module mux_4_1_n_bit_rr #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i0,
    input  logic [N-1:0] i1,
    input  logic [N-1:0] i2,
    input  logic [N-1:0] i3,
    input  logic         v0,
    input  logic         v1,
    input  logic         v2,
    input  logic         v3,
    output logic         r0,
    output logic         r1,
    output logic         r2,
    output logic         r3,
    output logic [N-1:0] out0,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         s0,
    output logic         s1
);

    logic [1:0]   ptr;
    logic         load;
    logic [3:0]   v;
    logic [3:0]   r;
    logic         grant_valid;
    logic [1:0]   grant_idx;
    logic [N-1:0] grant_data;

    assign v    = {v3, v2, v1, v0};
    assign load = ~out_valid | out_ready;

    // Scan from the farthest offset down to ptr so the closest valid channel is the one left standing.
    always_comb begin
        logic [1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        cand        = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (v[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        grant_data = i0;
        case (grant_idx)
            2'd0:    grant_data = i0;
            2'd1:    grant_data = i1;
            2'd2:    grant_data = i2;
            default: grant_data = i3;
        endcase
    end

    assign r = (rst_n & load & grant_valid) ? (4'b0001 << grant_idx) : 4'b0000;
    assign {r3, r2, r1, r0} = r;

    // A held word only leaves when the consumer takes it; draining and refilling can happen in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out0      <= '0;
            out_valid <= 1'b0;
            s1        <= 1'b0;
            s0        <= 1'b0;
            ptr       <= 2'd0;
        end else if (load) begin
            if (grant_valid) begin
                out0      <= grant_data;
                {s1, s0}  <= grant_idx;
                out_valid <= 1'b1;
                ptr       <= grant_idx + 2'd1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_4_1_n_bit_rr.sv
// Scoreboard bench for mux_4_1_n_bit_rr: a cycle-level arbitration model predicts grants and queues
// expected words, while an independent monitor pops and compares each word the consumer accepts.
module tb_mux_4_1_n_bit_rr;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] din [4];
    logic [3:0]   vin;
    logic         ordy;
    logic         r0, r1, r2, r3;
    logic [N-1:0] out0;
    logic         out_valid;
    logic         s0, s1;

    int n_checks = 0;
    int n_fails  = 0;

    logic [N+1:0] exp_q [$];
    bit           mov;
    int           mptr;

    mux_4_1_n_bit_rr #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i0        (din[0]),
        .i1        (din[1]),
        .i2        (din[2]),
        .i3        (din[3]),
        .v0        (vin[0]),
        .v1        (vin[1]),
        .v2        (vin[2]),
        .v3        (vin[3]),
        .r0        (r0),
        .r1        (r1),
        .r2        (r2),
        .r3        (r3),
        .out0      (out0),
        .out_valid (out_valid),
        .out_ready (ordy),
        .s0        (s0),
        .s1        (s1)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: first valid channel at ptr, ptr+1, ... (mod 4), or -1 if none.
    function automatic int model_grant(input logic [3:0] v, input int p);
        for (int off = 0; off < 4; off++)
            if (v[(p + off) % 4]) return (p + off) % 4;
        return -1;
    endfunction

    // One clock: inputs already driven at the falling edge; returns the channel granted (or -1).
    task automatic applyStimulus(output int g);
        bit ld;
        logic [3:0] er;
        #1;
        ld = !mov || ordy;
        g  = ld ? model_grant(vin, mptr) : -1;
        er = (g >= 0) ? 4'(1 << g) : 4'b0000;
        checkOutput("ready", {28'b0, r3, r2, r1, r0}, {28'b0, er});
        checkOutput("out_valid", {31'b0, out_valid}, {31'b0, mov});
        @(posedge clk);
        if (ld) begin
            if (g >= 0) begin
                exp_q.push_back({din[g], 2'(g)});
                mov  = 1'b1;
                mptr = (g + 1) % 4;
            end else begin
                mov = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_out0", {28'b0, out0}, 32'd0);
        checkOutput("rst_sel", {30'b0, s1, s0}, 32'd0);
        checkOutput("rst_ready", {28'b0, r3, r2, r1, r0}, 32'd0);
        exp_q.delete();
        mov  = 1'b0;
        mptr = 0;
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: a word is consumed at the next rising edge whenever out_valid & out_ready.
    initial begin
        logic [N+1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && ordy) begin
                if (exp_q.size() == 0) begin
                    checkOutput("sb_unexpected_word", {31'b0, out_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("sb_data", {28'b0, out0}, {28'b0, e[N+1:2]});
                    checkOutput("sb_source", {30'b0, s1, s0}, {30'b0, e[1:0]});
                end
            end
        end
    end

    initial begin
        int g;
        logic [N-1:0] rr_seq [4];
        rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100; rr_seq[3] = 4'b1000;
        mov  = 1'b0;
        mptr = 0;

        // Reset with every channel requesting.
        rst_n = 1'b0;
        vin = 4'hF;
        ordy = 1'b1;
        for (int k = 0; k < 4; k++) din[k] = rr_seq[k];
        #3;
        checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("reset_out0", {28'b0, out0}, 32'd0);
        checkOutput("reset_sel", {30'b0, s1, s0}, 32'd0);
        checkOutput("reset_ready", {28'b0, r3, r2, r1, r0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_reset_r0", {28'b0, r3, r2, r1, r0}, 32'h1);
        applyStimulus(g);
        checkOutput("post_reset_word", {26'b0, out0, s1, s0}, {26'b0, 4'b0001, 2'b00});

        // Single channel.
        vin = 4'b0100;
        din[2] = 4'b1100;
        applyStimulus(g);
        checkOutput("single_word", {25'b0, out_valid, out0, s1, s0}, {25'b0, 1'b1, 4'b1100, 2'b10});
        vin = 4'b0000;
        applyStimulus(g);
        checkOutput("single_drop", {31'b0, out_valid}, 32'd0);

        // Round robin from a fresh pointer.
        reset_pulse();
        vin = 4'hF;
        for (int k = 0; k < 4; k++) din[k] = rr_seq[k];
        for (int c = 0; c < 8; c++) begin
            applyStimulus(g);
            checkOutput("rr_data", {28'b0, out0}, {28'b0, rr_seq[c % 4]});
            checkOutput("rr_sel", {30'b0, s1, s0}, 32'(c % 4));
        end

        // Backpressure: channel 1 word held, ptr=2, channel 3 must win over channel 0.
        vin = 4'b0010;
        din[1] = 4'b0110;
        applyStimulus(g);
        vin = 4'b1001;
        din[0] = 4'b0011;
        din[3] = 4'b1010;
        ordy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(g);
            checkOutput("bp_hold", {26'b0, out0, s1, s0}, {26'b0, 4'b0110, 2'b01});
        end
        ordy = 1'b1;
        applyStimulus(g);
        checkOutput("bp_next", {26'b0, out0, s1, s0}, {26'b0, 4'b1010, 2'b11});

        // Skip and wrap: ptr=3, only channel 1 valid.
        vin = 4'b0100;
        din[2] = 4'b0101;
        applyStimulus(g);
        vin = 4'b0010;
        din[1] = 4'b1001;
        applyStimulus(g);
        checkOutput("wrap_sel", {26'b0, out0, s1, s0}, {26'b0, 4'b1001, 2'b01});
        vin = 4'hF;
        applyStimulus(g);
        checkOutput("wrap_ptr2", {30'b0, s1, s0}, 32'd2);

        // Mid-operation reset with a word held.
        ordy = 1'b0;
        applyStimulus(g);
        reset_pulse();
        ordy = 1'b1;
        applyStimulus(g);
        checkOutput("restart_ch0", {30'b0, s1, s0}, 32'd0);

        // Randomized traffic with protocol-respecting producers.
        vin = 4'b0000;
        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (!vin[k] && ($urandom_range(0, 1) == 1)) begin
                    vin[k] = 1'b1;
                    din[k] = N'($urandom);
                end
            end
            ordy = ($urandom_range(0, 3) != 0);
            applyStimulus(g);
            if (g >= 0) vin[g] = 1'b0;
        end

        // Drain.
        vin = 4'b0000;
        ordy = 1'b1;
        for (int c = 0; c < 3; c++) applyStimulus(g);
        checkOutput("drain_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/mux_4_1_n_bit_rr.md
Name: mux_4_1_n_bit_rr

Overview:
- Four-input, N-bit stream multiplexer with round-robin arbitration and a registered output. It is the collecting counterpart of demux_1_4_n_bit.
- Merges up to four producer channels (i0..i3) into one output stream, out0.
- Reports which channel each output word came from on s1:s0, using the same select encoding the demux consumes. A downstream demux can therefore re-split the stream.
- Uses valid/ready handshakes on every side. Sits between four parallel datapaths and one shared consumer.

Parameters:
- N, 4, data width of every input channel and of out0.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- i0  input  N  channel 0 data.
- i1  input  N  channel 1 data.
- i2  input  N  channel 2 data.
- i3  input  N  channel 3 data.
- v0..v3  input  1 each  channel k data valid.
- r0..r3  output  1 each  channel k ready; a transfer occurs when vk & rk at a clk edge.
- out0  output  N  registered output data.
- out_valid  output  1  out0/s0/s1 hold a word.
- out_ready  input  1  consumer accepts the word when out_valid & out_ready at a clk edge.
- s0  output  1  source index bit 0 of the current word.
- s1  output  1  source index bit 1 of the current word; index = {s1,s0}.

Behaviour:
- Internal state:
  - Output register {out0, s1, s0, out_valid}.
  - 2-bit round-robin pointer ptr, which holds the highest-priority channel index.
- Reset:
  - While rst_n is low, asynchronously: out0=0, out_valid=0, s1=s0=0, ptr=0.
  - r0..r3 are forced to 0 while rst_n is low.
- load = ~out_valid | out_ready. The output register can take a new word this cycle.
- Grant (combinational):
  - Search v[ptr], v[ptr+1], v[ptr+2], v[ptr+3], indices mod 4.
  - The first asserted channel is g. If none is asserted, there is no grant.
- Ready: rk = rst_n & load & (grant exists) & (g==k). At most one rk is high per cycle.
- Clock edge with load and a grant:
  - out0<=i[g], {s1,s0}<=g, out_valid<=1, ptr<=g+1 mod 4.
  - Latency is one cycle from vk&rk to the word on out0.
- Clock edge with load and no grant: out_valid<=0. out0, s1, s0 and ptr hold their values.
- Clock edge without load (out_valid & ~out_ready): all state holds and all rk=0. out0/s1/s0 stay stable until accepted (backpressure).
- Simultaneous drain and fill: with out_valid & out_ready and a grant in the same cycle, the new word replaces the old one with no bubble. Full throughput is one word per clock.
- Fairness:
  - With all four channels continuously valid and out_ready=1, grants rotate 0,1,2,3,0,...
  - No channel waits more than 3 transfers once it is valid.
- Pointer wrap: g=3 gives ptr=0.
- Protocol: inputs must hold ik stable while vk is high and not yet accepted. The block does not check this.
- Reset mid-operation: any word held in the output register is discarded. out_valid drops immediately and asynchronously. The pending input handshake does not complete.
- Combinational paths exist from v0..v3 and out_ready to r0..r3. There is no path from any input to out0/out_valid/s0/s1.

Test Plan:
- Reset: assert rst_n=0 with v0..v3=1. Required: out_valid=0, out0=0000, s1s0=00, r0..r3=0. Release rst_n; on the next cycle r0=1, then out0=i0 with s1s0=00.
- Single channel: i2=1100, only v2=1, out_ready=1. Required: r2=1 and others 0; the next cycle gives out0=1100, s1s0=10, out_valid=1. Drop v2; the cycle after gives out_valid=0.
- Round robin: i0=0001, i1=0010, i2=0100, i3=1000, all valid, out_ready=1 for 8 cycles. Required out0 sequence: 0001,0010,0100,1000,0001,0010,0100,1000, with s1s0 00,01,10,11 repeating.
- Backpressure: out_valid=1 holding 0110 from channel 1, then out_ready=0 for 5 cycles while v0=v3=1. Required: out0=0110 and s1s0=01 stable, r0..r3=0. Raise out_ready; the next word is channel 3 (ptr=2 skips empty channel 2), not channel 0.
- Skip/wrap: ptr=3 and only v1=1. Required: grant to channel 1, s1s0=01, ptr becomes 2.
- Mid-operation reset: out_valid=1 with a word held, pulse rst_n low for a half cycle. Required: out_valid=0 and out0=0000 immediately. After release, arbitration restarts at channel 0.
